key_debounce_pulse: RTL and testbench
=====================================

Name: key_debounce_pulse

Overview:
Front-end conditioning stage for the lab-07 master-slave JK flip-flop. It takes the raw, bouncing, active-low push-button and the two slide switches (J, K). It delivers a clean debounced key level (the flip-flop's clock source), single-cycle press/release strobes, synchronized J/K levels and an 8-bit press counter for LEDs. It sits directly upstream of the flip-flop and drives its key, J and K inputs.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a key change (10 ms at 50 MHz); minimum 2
CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1
REPEAT_DELAY, 25000000, cycles held before first auto-repeat (used only with AUTO_REPEAT_EN)
REPEAT_PERIOD, 5000000, cycles between auto-repeat strobes (used only with AUTO_REPEAT_EN)

Ports:
clk  input  1  system clock, 50 MHz board clock
rst  input  1  asynchronous, active-high reset
key_n  input  1  raw push-button, 0 = pressed, asynchronous
sw_j  input  1  raw J switch, asynchronous
sw_k  input  1  raw K switch, asynchronous
key_db  output  1  debounced key, same polarity as key_n (1 = released); feeds flip-flop key
pressed  output  1  debounced level, 1 = held
press_pulse  output  1  one-cycle strobe on accepted press
release_pulse  output  1  one-cycle strobe on accepted release
j_sync  output  1  2-flop synchronized sw_j
k_sync  output  1  2-flop synchronized sw_k
press_cnt  output  8  count of accepted presses

Behaviour:
- Reset (async, rst=1): all synchronizer flops = idle level (key = 1, J/K = 0). FSM = UP. cnt = 0. key_db = 1, pressed = 0, pulses = 0, j_sync = k_sync = 0, press_cnt = 0.
- key_n, sw_j, sw_k each pass through a 2-flop synchronizer; no combinational path from raw inputs to outputs.
- FSM states: UP (stable released), WAIT_DN, DOWN (stable pressed), WAIT_UP.
  - UP: synced key = 0 -> WAIT_DN, cnt <= 0.
  - WAIT_DN: synced key = 1 -> UP, cnt <= 0 (bounce rejected, no pulse). Else if cnt == DEBOUNCE_CYCLES-1 -> DOWN, cnt <= 0. Else cnt <= cnt+1.
  - DOWN and WAIT_UP mirror UP and WAIT_DN with polarity swapped.
- Outputs are registered and update on the commit edge. Entering DOWN: pressed <= 1, key_db <= 0, press_pulse <= 1 for exactly one cycle, press_cnt <= press_cnt+1. Entering UP from WAIT_UP: pressed <= 0, key_db <= 1, release_pulse <= 1 for one cycle.
- Latency: a clean raw step is reflected on key_db/pressed exactly DEBOUNCE_CYCLES+3 clk edges later. j_sync/k_sync lag by 2 edges.
- press_cnt wraps 255 -> 0 silently.
- press_pulse and release_pulse are never both 1. Two consecutive strobes are separated by at least DEBOUNCE_CYCLES+1 cycles.
- A glitch of length < DEBOUNCE_CYCLES synced cycles produces no output change.
- Reset asserted mid-WAIT_*: immediate return to reset values. After release, a still-held key is re-debounced from UP and produces a fresh press_pulse.

Optional Feature:
AUTO_REPEAT_EN
- Defined: while in DOWN, a repeat counter starts on entry. After REPEAT_DELAY cycles it emits press_pulse and increments press_cnt, then does so every REPEAT_PERIOD cycles until the FSM leaves DOWN. The repeat counter clears on exit from DOWN and on reset. key_db/pressed are unaffected.
- Undefined: exactly one press_pulse per accepted press; repeat counter and parameters unused; no extra logic.

Decomposition:
- Package lab07_pkg: state enum (UP, WAIT_DN, DOWN, WAIT_UP); default DEBOUNCE_CYCLES constant; key idle-level constant (1).
- Sub-module sync2 (two-flop synchronizer, async reset to a parameterized idle value), instantiated three times (key, J, K).

Test Plan:
(DEBOUNCE_CYCLES=8 for simulation)
1. Reset: rst=1 with key_n=0, sw_j=1 -> key_db=1, pressed=0, press_cnt=0, j_sync=0; after rst=0, key_db falls at edge 11 with press_pulse=1 for one cycle.
2. Clean press: key_n 1->0 held 20 cycles -> key_db=0 exactly 11 edges after the change, press_pulse one cycle, press_cnt=1; release -> release_pulse one cycle 11 edges later.
3. Bounce: key_n low 5 cycles, high 2, low 3, then high -> no change on key_db, no pulses, press_cnt stays 0.
4. Wrap: 256 clean presses -> press_cnt returns to 0, exactly 256 press_pulse and 256 release_pulse.
5. Reset mid-WAIT_DN: press, assert rst at cycle 6 for 2 cycles with key still held -> outputs at reset values, then press_pulse again 11 edges after rst deasserts.
6. AUTO_REPEAT_EN (REPEAT_DELAY=20, REPEAT_PERIOD=10): hold 60 cycles after commit -> press_pulse at +0, +20, +30, +40, +50; press_cnt=5; no repeat strobes after release.

Source files
------------

// File: rtl/lab07_pkg.sv
// rtl/lab07_pkg.sv - shared types and constants for the lab-07 key front end
package lab07_pkg;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    WAIT_DN = 2'd1,
    DOWN    = 2'd2,
    WAIT_UP = 2'd3
  } state_t;

  // 10 ms of stability at the 50 MHz board clock
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  // push-button rests high (released)
  localparam logic KEY_IDLE = 1'b1;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with asynchronous reset to a chosen idle level
module sync2 #(
  parameter logic IDLE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= IDLE;
      q  <= IDLE;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/key_debounce_pulse.sv
// rtl/key_debounce_pulse.sv - debounced key, press/release strobes, synced J/K, press counter
// Optional press auto-repeat while held: define AUTO_REPEAT_EN.
module key_debounce_pulse
  import lab07_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic       sw_j,
  input  logic       sw_k,
  output logic       key_db,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       j_sync,
  output logic       k_sync,
  output logic [7:0] press_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             commit_dn, commit_up;
  logic             rpt_fire;

  sync2 #(.IDLE(KEY_IDLE)) u_sync_key (.clk(clk), .rst(rst), .d(key_n), .q(key_s));
  sync2 #(.IDLE(1'b0))     u_sync_j   (.clk(clk), .rst(rst), .d(sw_j),  .q(j_sync));
  sync2 #(.IDLE(1'b0))     u_sync_k   (.clk(clk), .rst(rst), .d(sw_k),  .q(k_sync));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // any opposite-level sample in a WAIT state rejects the edge as bounce
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit_dn = 1'b0;
    commit_up = 1'b0;
    case (state)
      UP: begin
        if (!key_s) begin
          state_nxt = WAIT_DN;
          cnt_nxt   = '0;
        end
      end
      WAIT_DN: begin
        if (key_s) begin
          state_nxt = UP;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
          commit_dn = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DOWN: begin
        if (key_s) begin
          state_nxt = WAIT_UP;
          cnt_nxt   = '0;
        end
      end
      WAIT_UP: begin
        if (!key_s) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = UP;
          cnt_nxt   = '0;
          commit_up = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = UP;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [31:0] RPT_FIRST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RPT_NEXT  = 32'(REPEAT_PERIOD - 1);

  logic [31:0] rpt_cnt;
  logic        rpt_first;
  logic        in_down;

  assign in_down  = (state == DOWN) && (state_nxt == DOWN);
  assign rpt_fire = in_down && (rpt_cnt == (rpt_first ? RPT_FIRST : RPT_NEXT));

  // first strobe waits the long delay, later ones the shorter period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (!in_down) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else begin
      rpt_cnt <= rpt_cnt + 32'd1;
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rpt_fire   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_db        <= KEY_IDLE;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_cnt     <= '0;
    end else begin
      press_pulse   <= commit_dn | rpt_fire;
      release_pulse <= commit_up;
      if (commit_dn) begin
        key_db  <= 1'b0;
        pressed <= 1'b1;
      end else if (commit_up) begin
        key_db  <= 1'b1;
        pressed <= 1'b0;
      end
      if (commit_dn || rpt_fire)
        press_cnt <= press_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb/tb_key_debounce_pulse.sv - directed self-checking bench for key_debounce_pulse (DEBOUNCE_CYCLES=8)
module tb_key_debounce_pulse;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_n;
  logic       sw_j;
  logic       sw_k;
  logic       key_db;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       j_sync;
  logic       k_sync;
  logic [7:0] press_cnt;

  int ntests = 0;
  int nfail  = 0;
  int npress = 0;
  int nrel   = 0;
  int np0, nr0;

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(8),
    .CNT_W(20),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .sw_j(sw_j),
    .sw_k(sw_k),
    .key_db(key_db),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .j_sync(j_sync),
    .k_sync(k_sync),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // key_n falls just after an edge; commit lands on the 11th edge
  task automatic press_check(input logic [7:0] exp_cnt);
    key_n = 1'b0;
    step(10);
    chk("press_e10_key_db", 32'(key_db), 32'd1);
    chk("press_e10_pulse", 32'(press_pulse), 32'd0);
    step(1);
    chk("press_e11_key_db", 32'(key_db), 32'd0);
    chk("press_e11_pressed", 32'(pressed), 32'd1);
    chk("press_e11_pulse", 32'(press_pulse), 32'd1);
    chk("press_e11_cnt", 32'(press_cnt), 32'(exp_cnt));
    step(1);
    chk("press_e12_pulse", 32'(press_pulse), 32'd0);
    step(8);
  endtask

  task automatic release_check();
    key_n = 1'b1;
    step(10);
    chk("rel_e10_key_db", 32'(key_db), 32'd0);
    chk("rel_e10_pulse", 32'(release_pulse), 32'd0);
    step(1);
    chk("rel_e11_key_db", 32'(key_db), 32'd1);
    chk("rel_e11_pressed", 32'(pressed), 32'd0);
    chk("rel_e11_pulse", 32'(release_pulse), 32'd1);
    step(1);
    chk("rel_e12_pulse", 32'(release_pulse), 32'd0);
    step(8);
  endtask

  always @(negedge clk) begin
    if (press_pulse) npress++;
    if (release_pulse) nrel++;
    if (press_pulse || release_pulse)
      chk("pulse_exclusive", 32'(press_pulse & release_pulse), 32'd0);
  end

  initial begin
    rst   = 1'b1;
    key_n = 1'b0;
    sw_j  = 1'b1;
    sw_k  = 1'b0;
    step(3);
    chk("rst_key_db", 32'(key_db), 32'd1);
    chk("rst_pressed", 32'(pressed), 32'd0);
    chk("rst_press_cnt", 32'(press_cnt), 32'd0);
    chk("rst_j_sync", 32'(j_sync), 32'd0);
    chk("rst_pulses", 32'({press_pulse, release_pulse}), 32'd0);

    // key already held at reset release: debounced from UP
    rst = 1'b0;
    step(1);
    chk("j_sync_e1", 32'(j_sync), 32'd0);
    step(1);
    chk("j_sync_e2", 32'(j_sync), 32'd1);
    step(8);
    chk("t1_e10_key_db", 32'(key_db), 32'd1);
    step(1);
    chk("t1_e11_key_db", 32'(key_db), 32'd0);
    chk("t1_e11_pulse", 32'(press_pulse), 32'd1);
    chk("t1_e11_cnt", 32'(press_cnt), 32'd1);
    step(1);
    chk("t1_e12_pulse", 32'(press_pulse), 32'd0);
    step(8);
    release_check();

    sw_k = 1'b1;
    step(1);
    chk("k_sync_e1", 32'(k_sync), 32'd0);
    step(1);
    chk("k_sync_e2", 32'(k_sync), 32'd1);

    press_check(8'd2);
    release_check();

    // bounce: 5 low, 2 high, 3 low, then released
    np0 = npress;
    nr0 = nrel;
    key_n = 1'b0; step(5);
    key_n = 1'b1; step(2);
    key_n = 1'b0; step(3);
    key_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (i % 5 == 4) chk("bounce_key_db", 32'(key_db), 32'd1);
    end
    chk("bounce_press_pulses", 32'(npress - np0), 32'd0);
    chk("bounce_rel_pulses", 32'(nrel - nr0), 32'd0);
    chk("bounce_cnt", 32'(press_cnt), 32'd2);

    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
    chk("wrap_start_cnt", 32'(press_cnt), 32'd0);
    np0 = npress;
    nr0 = nrel;
    for (int i = 0; i < 256; i++) begin
      key_n = 1'b0;
      step(14);
      if (i == 254) chk("wrap_cnt_255", 32'(press_cnt), 32'd255);
      key_n = 1'b1;
      step(14);
    end
    step(2);
    chk("wrap_press_pulses", 32'(npress - np0), 32'd256);
    chk("wrap_rel_pulses", 32'(nrel - nr0), 32'd256);
    chk("wrap_cnt_0", 32'(press_cnt), 32'd0);

    press_check(8'd1);
    release_check();

    // reset in the middle of WAIT_DN with key still held
    key_n = 1'b0;
    step(6);
    rst = 1'b1;
    #1;
    chk("midrst_key_db", 32'(key_db), 32'd1);
    chk("midrst_pressed", 32'(pressed), 32'd0);
    chk("midrst_cnt", 32'(press_cnt), 32'd0);
    chk("midrst_j_sync", 32'(j_sync), 32'd0);
    step(2);
    rst = 1'b0;
    step(10);
    chk("midrst_e10_key_db", 32'(key_db), 32'd1);
    step(1);
    chk("midrst_e11_key_db", 32'(key_db), 32'd0);
    chk("midrst_e11_pulse", 32'(press_pulse), 32'd1);
    chk("midrst_e11_cnt", 32'(press_cnt), 32'd1);
    step(1);
    chk("midrst_e12_pulse", 32'(press_pulse), 32'd0);

`ifdef AUTO_REPEAT_EN
    for (int k = 2; k <= 51; k++) begin
      step(1);
      chk("repeat_pulse", 32'(press_pulse),
          32'((k == 20) || (k == 30) || (k == 40) || (k == 50)));
    end
    np0 = npress;
    key_n = 1'b1;
    step(30);
    chk("repeat_cnt", 32'(press_cnt), 32'd5);
    chk("repeat_after_release", 32'(npress - np0), 32'd0);
    chk("repeat_pressed", 32'(pressed), 32'd0);
`else
    np0 = npress;
    step(60);
    chk("norepeat_pulses", 32'(npress - np0), 32'd0);
    key_n = 1'b1;
    step(30);
    chk("norepeat_cnt", 32'(press_cnt), 32'd1);
    chk("norepeat_pressed", 32'(pressed), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
